// File: rtl/jump_redirect_ctrl.sv
// Jump/branch redirect sequencer for J, JAL and JR. Drives the registered
// jump-target shifter, forms the target and hands it to fetch under valid/ready.
//
// state | meaning
// IDLE  | ready for a new instruction from decode
// SHIFT | shift_in held while the external shifter registers it
// CAPT  | shifter output valid; capture {hi4, shift_out} as target
// ISSUE | redirect_valid high, waiting for fetch to accept
module jump_redirect_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] rs_data_i,
    output logic        instr_ready_o,
    output logic [25:0] shift_in_o,
    input  logic [27:0] shift_out_i,
    output logic        redirect_valid_o,
    input  logic        redirect_ready_i,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        link_we_o,
    output logic [4:0]  link_addr_o,
    output logic [31:0] link_data_o,
    output logic        addr_err_o,
    input  logic        abort_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CAPT  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [25:0] shift_in_q, shift_in_d;
    logic [3:0]  hi4_q, hi4_d;
    logic        is_jal_q, is_jal_d;
    logic [31:0] link_data_q, link_data_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        flush_q, flush_d;
    logic        link_we_q, link_we_d;
    logic        addr_err_q, addr_err_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       dec_j, dec_jal, dec_jr;

    assign opcode  = instr_i[31:26];
    assign funct   = instr_i[5:0];
    assign dec_j   = (opcode == 6'b000010);
    assign dec_jal = (opcode == 6'b000011);
    assign dec_jr  = (opcode == 6'b000000) && (funct == 6'b001000);

    always_comb begin
        state_d       = state_q;
        shift_in_d    = shift_in_q;
        hi4_d         = hi4_q;
        is_jal_d      = is_jal_q;
        link_data_d   = link_data_q;
        redirect_pc_d = redirect_pc_q;
        flush_d       = 1'b0;
        link_we_d     = 1'b0;
        addr_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // abort in IDLE drops whatever decode presents this cycle
                if (instr_valid_i && !abort_i) begin
                    if (dec_j || dec_jal) begin
                        shift_in_d  = instr_i[25:0];
                        hi4_d       = pc_plus4_i[31:28];
                        is_jal_d    = dec_jal;
                        link_data_d = pc_plus4_i;
                        state_d     = SHIFT;
                    end else if (dec_jr) begin
                        if (rs_data_i[1:0] == 2'b00) begin
                            redirect_pc_d = rs_data_i;
                            is_jal_d      = 1'b0;
                            state_d       = ISSUE;
                        end else begin
                            addr_err_d = 1'b1;
                        end
                    end
                end
            end
            SHIFT: begin
                state_d = abort_i ? IDLE : CAPT;
            end
            CAPT: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    redirect_pc_d = {hi4_q, shift_out_i};
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (redirect_ready_i) begin
                    flush_d   = 1'b1;
                    link_we_d = is_jal_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shift_in_q    <= '0;
            hi4_q         <= '0;
            is_jal_q      <= 1'b0;
            link_data_q   <= '0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
            link_we_q     <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_in_q    <= shift_in_d;
            hi4_q         <= hi4_d;
            is_jal_q      <= is_jal_d;
            link_data_q   <= link_data_d;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= flush_d;
            link_we_q     <= link_we_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign instr_ready_o    = (state_q == IDLE);
    assign redirect_valid_o = (state_q == ISSUE);
    assign shift_in_o       = shift_in_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign flush_o          = flush_q;
    assign link_we_o        = link_we_q;
    assign link_addr_o      = link_we_q ? 5'd31 : 5'd0;
    assign link_data_o      = link_data_q;
    assign addr_err_o       = addr_err_q;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Bench for jump_redirect_ctrl: directed scenarios plus random traffic checked
// against a transaction-level model (busy flag + cycles-to-issue countdown).
module tb_jump_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr, pc_plus4, rs_data;
    logic        instr_ready;
    logic [25:0] shift_in;
    logic [27:0] shift_out;
    logic        redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;
    logic        flush, link_we;
    logic [4:0]  link_addr;
    logic [31:0] link_data;
    logic        addr_err, abort;

    int n_chk = 0;
    int n_err = 0;

    jump_redirect_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instr_valid_i    (instr_valid),
        .instr_i          (instr),
        .pc_plus4_i       (pc_plus4),
        .rs_data_i        (rs_data),
        .instr_ready_o    (instr_ready),
        .shift_in_o       (shift_in),
        .shift_out_i      (shift_out),
        .redirect_valid_o (redirect_valid),
        .redirect_ready_i (redirect_ready),
        .redirect_pc_o    (redirect_pc),
        .flush_o          (flush),
        .link_we_o        (link_we),
        .link_addr_o      (link_addr),
        .link_data_o      (link_data),
        .addr_err_o       (addr_err),
        .abort_i          (abort)
    );

    always #5 clk = ~clk;

    // external registered 26->28 jump-target shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shift_out <= '0;
        else        shift_out <= {shift_in, 2'b00};
    end

    // reference model: idle/busy, cycles left until the redirect is offered
    logic        m_busy;
    int          m_left;
    logic [31:0] m_pc, m_tgt, m_link;
    logic [25:0] m_shin;
    logic        m_jal, m_flush, m_lwe, m_aerr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_left = 0; m_pc = 0; m_tgt = 0; m_link = 0; m_shin = 0;
        m_jal = 0; m_flush = 0; m_lwe = 0; m_aerr = 0;
    endtask

    task automatic model_step();
        logic [5:0] op;
        op = instr[31:26];
        m_flush = 0; m_lwe = 0; m_aerr = 0;
        if (!m_busy) begin
            if (instr_valid && !abort) begin
                if (op == 6'd2 || op == 6'd3) begin
                    m_busy = 1; m_left = 2;
                    m_tgt  = {pc_plus4[31:28], instr[25:0], 2'b00};
                    m_jal  = (op == 6'd3);
                    m_shin = instr[25:0];
                    m_link = pc_plus4;
                end else if (op == 6'd0 && instr[5:0] == 6'd8) begin
                    if (rs_data % 4 == 0) begin
                        m_busy = 1; m_left = 0; m_pc = rs_data; m_jal = 0;
                    end else begin
                        m_aerr = 1;
                    end
                end
            end
        end else if (abort) begin
            m_busy = 0;
        end else if (m_left > 0) begin
            if (m_left == 1) m_pc = m_tgt;
            m_left--;
        end else if (redirect_ready) begin
            m_busy = 0; m_flush = 1; m_lwe = m_jal;
        end
    endtask

    task automatic check_all();
        chk("instr_ready", instr_ready, !m_busy);
        chk("redirect_valid", redirect_valid, m_busy && m_left == 0);
        chk("redirect_pc", redirect_pc, m_pc);
        chk("redirect_pc_lsb", redirect_pc[1:0], 0);
        chk("shift_in", shift_in, m_shin);
        chk("flush", flush, m_flush);
        chk("link_we", link_we, m_lwe);
        chk("link_addr", link_addr, m_lwe ? 31 : 0);
        chk("link_data", link_data, m_link);
        chk("addr_err", addr_err, m_aerr);
    endtask

    // one clock: DUT and model advance on the edge, outputs compared at negedge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] r, input logic rdy, input logic ab);
        instr_valid = v; instr = i; pc_plus4 = p; rs_data = r;
        redirect_ready = rdy; abort = ab;
    endtask

    task automatic gen_instr();
        int k;
        k = $urandom_range(0, 5);
        pc_plus4 = $urandom & 32'hFFFF_FFFC;
        rs_data  = $urandom & 32'hFFFF_FFFC;
        case (k)
            0: instr = {6'd2, 26'($urandom)};
            1: instr = {6'd3, 26'($urandom)};
            2: instr = {6'd0, 20'($urandom), 6'd8};
            3: begin
                instr   = {6'd0, 20'($urandom), 6'd8};
                rs_data = rs_data | 32'($urandom_range(1, 3));
            end
            4: instr = {6'($urandom_range(4, 63)), 26'($urandom)};
            default: instr = {6'd0, 20'($urandom), 6'($urandom_range(9, 63))};
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // J with fetch always ready
        drive(1, 32'h0810_0004, 32'hA000_0010, 0, 1, 0);
        cycle();
        instr_valid = 0;
        cycle();
        chk("j_not_yet_valid", redirect_valid, 0);
        cycle();
        chk("j_valid_3cyc", redirect_valid, 1);
        chk("j_target", redirect_pc, 32'hA040_0010);
        cycle();
        chk("j_flush", flush, 1);
        chk("j_no_link", link_we, 0);
        cycle();
        chk("j_flush_one_cycle", flush, 0);

        // JAL with fetch stalled for 4 cycles
        drive(1, 32'h0C00_0040, 32'h0040_0008, 0, 0, 0);
        cycle();
        instr_valid = 0;
        cycle();
        cycle();
        for (int n = 0; n < 4; n++) begin
            chk("jal_stall_valid", redirect_valid, 1);
            chk("jal_stall_pc", redirect_pc, 32'h0000_0100);
            chk("jal_stall_no_flush", flush, 0);
            if (n < 3) cycle();
        end
        redirect_ready = 1;
        cycle();
        chk("jal_link_we", link_we, 1);
        chk("jal_link_addr", link_addr, 31);
        chk("jal_link_data", link_data, 32'h0040_0008);
        chk("jal_flush", flush, 1);
        cycle();
        chk("jal_link_we_one_cycle", link_we, 0);
        chk("jal_link_addr_zero", link_addr, 0);

        // JR aligned, then misaligned
        drive(1, 32'h03E0_0008, 0, 32'h0040_0020, 1, 0);
        cycle();
        instr_valid = 0;
        chk("jr_valid_1cyc", redirect_valid, 1);
        chk("jr_target", redirect_pc, 32'h0040_0020);
        cycle();
        chk("jr_flush", flush, 1);
        drive(1, 32'h03E0_0008, 0, 32'h0040_0022, 1, 0);
        cycle();
        instr_valid = 0;
        chk("jr_mis_addr_err", addr_err, 1);
        chk("jr_mis_no_redirect", redirect_valid, 0);
        cycle();
        chk("jr_mis_err_one_cycle", addr_err, 0);
        chk("jr_mis_no_flush", flush, 0);

        // abort racing redirect_ready in ISSUE
        drive(1, 32'h0C00_1234, 32'h1000_0000, 0, 0, 0);
        cycle();
        instr_valid = 0;
        cycle();
        cycle();
        chk("abort_in_issue", redirect_valid, 1);
        redirect_ready = 1; abort = 1;
        cycle();
        abort = 0;
        chk("abort_idle", instr_ready, 1);
        chk("abort_no_flush", flush, 0);
        chk("abort_no_link", link_we, 0);

        // backpressure: second J held during SHIFT/CAPT/ISSUE
        drive(1, 32'h0800_0001, 32'h3000_0000, 0, 1, 0);
        cycle();
        instr = 32'h0BFF_FFFF; pc_plus4 = 32'h5000_0004;
        for (int n = 0; n < 3; n++) begin
            chk("busy_not_ready", instr_ready, 0);
            cycle();
        end
        chk("bp_first_flush", flush, 1);
        chk("bp_first_ready", instr_ready, 1);
        cycle();
        instr_valid = 0;
        chk("bp_second_accepted", instr_ready, 0);
        cycle();
        cycle();
        chk("bp_second_target", redirect_pc, 32'h5FFF_FFFC);
        cycle();

        // asynchronous reset in the middle of SHIFT
        drive(1, 32'h0812_3456, 32'h7000_0000, 0, 1, 0);
        cycle();
        instr_valid = 0;
        chk("rst_in_shift", instr_ready, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_async_ready", instr_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        cycle();
        chk("rst_no_redirect", redirect_valid, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if (!m_busy) begin
                gen_instr();
                instr_valid = ($urandom_range(0, 3) != 0);
            end
            redirect_ready = ($urandom_range(0, 9) < 6);
            abort          = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
